// File: rtl/fmsg_arbiter.sv
// Four-requester round-robin fmsg arbiter with a one-deep output register and a sticky downstream-stall flag.
// Optional macro FMSG_ARB_URGENT_PRIO_EN: TYPE==2'b11 requests take priority over all other requests.
module fmsg_arbiter #(
    parameter int STALL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_fmsg,
    output logic [3:0]  req_ready,
    output logic        out_valid,
    output logic [7:0]  out_fmsg,
    output logic [1:0]  out_src,
    input  logic        out_ready,
    input  logic        err_clr,
    output logic        stall_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;
    localparam logic [7:0] LIMIT  = 8'(STALL_LIMIT);

    logic [0:0] r_state;
    logic [7:0] r_out_fmsg;
    logic [1:0] r_out_src;
    logic [1:0] r_rr_ptr;
    logic [7:0] r_stall_cnt;
    logic       r_stall_err;

    logic [7:0] w_words [4];
    logic [3:0] w_mask;
    logic       w_load;
    logic       w_found;
    logic       w_grant;
    logic       w_stall;
    logic       w_stall_set;
    logic [1:0] w_win_idx;
    logic [1:0] w_scan_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_words
            assign w_words[gi] = req_fmsg[8*gi +: 8];
        end
    endgenerate

`ifdef FMSG_ARB_URGENT_PRIO_EN
    logic [3:0] w_urgent;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_urgent
            assign w_urgent[gi] = req_valid[gi] & (w_words[gi][7:6] == 2'b11);
        end
    endgenerate
    assign w_mask = (|w_urgent) ? w_urgent : req_valid;
`else
    assign w_mask = req_valid;
`endif

    // First candidate found scanning upward from the round-robin pointer.
    always_comb begin
        w_found    = 1'b0;
        w_win_idx  = 2'd0;
        w_scan_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_scan_idx = r_rr_ptr + 2'(k);
            if (!w_found && w_mask[w_scan_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_scan_idx;
            end
        end
    end

    assign out_valid   = (r_state == S_FULL);
    assign out_fmsg    = r_out_fmsg;
    assign out_src     = r_out_src;
    assign stall_err   = r_stall_err;
    assign w_load      = !out_valid | out_ready;
    // rst gates the grant so nothing is offered while reset is held.
    assign w_grant     = w_load & w_found & !rst;
    assign req_ready   = w_grant ? (4'b0001 << w_win_idx) : 4'b0000;
    assign w_stall     = out_valid & !out_ready;
    assign w_stall_set = w_stall && (r_stall_cnt >= LIMIT - 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_out_fmsg <= 8'h00;
            r_out_src  <= 2'd0;
            r_rr_ptr   <= 2'd0;
        end else if (w_grant) begin
            r_state    <= S_FULL;
            r_out_fmsg <= w_words[w_win_idx];
            r_out_src  <= w_win_idx;
            r_rr_ptr   <= w_win_idx + 2'd1;
        end else if (out_valid && out_ready) begin
            r_state    <= S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 8'd0;
            r_stall_err <= 1'b0;
        end else begin
            if (!w_stall) begin
                r_stall_cnt <= 8'd0;
            end else if (r_stall_cnt < LIMIT) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
            if (w_stall_set) begin
                r_stall_err <= 1'b1;
            end else if (err_clr) begin
                r_stall_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fmsg_arbiter.sv
// Directed bench for fmsg_arbiter (STALL_LIMIT = 3): round-robin order, stall hold, stall flag, priority, mid-run reset.
module tb_fmsg_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'd0;
    logic [31:0] req_fmsg = 32'd0;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_fmsg;
    logic [1:0]  out_src;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        stall_err;

    int checks = 0;
    int failures = 0;

    fmsg_arbiter #(.STALL_LIMIT(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_fmsg(req_fmsg),
        .req_ready(req_ready), .out_valid(out_valid), .out_fmsg(out_fmsg),
        .out_src(out_src), .out_ready(out_ready), .err_clr(err_clr),
        .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        // Reset held with all requesters active: nothing may be granted.
        req_valid = 4'b1111;
        req_fmsg  = {8'h13, 8'h12, 8'h11, 8'h10};
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_fmsg",  32'(out_fmsg),  32'h00);
        check("rst_out_src",   32'(out_src),   32'd0);
        check("rst_stall_err", 32'(stall_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);

        // Full round robin with everyone requesting and downstream always ready.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(4'b0001 << (i % 4)));
            tick();
            check($sformatf("rr_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("rr_src_%0d", i),   32'(out_src),   32'(i % 4));
            check($sformatf("rr_fmsg_%0d", i),  32'(out_fmsg),  32'(8'h10 + i % 4));
        end

        // Drain: valid drops, data and source hold.
        req_valid = 4'b0000;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_src",   32'(out_src),   32'd0);
        check("drain_fmsg",  32'(out_fmsg),  32'h10);

        // Requester 2 alone, downstream stalled for 5 cycles.
        req_valid = 4'b0100;
        req_fmsg  = 32'h00A5_0000;
        out_ready = 1'b0;
        #1;
        check("stall_first_grant", 32'(req_ready), 32'b0100);
        tick();
        for (int n = 1; n <= 5; n++) begin
            check($sformatf("stall_fmsg_%0d", n),  32'(out_fmsg),  32'hA5);
            check($sformatf("stall_src_%0d", n),   32'(out_src),   32'd2);
            check($sformatf("stall_valid_%0d", n), 32'(out_valid), 32'd1);
            check($sformatf("stall_ready_%0d", n), 32'(req_ready), 32'd0);
            check($sformatf("stall_err_%0d", n),   32'(stall_err), 32'(n >= 4));
            tick();
        end

        // Downstream resumes: flag stays sticky until err_clr.
        req_valid = 4'b0000;
        out_ready = 1'b1;
        #1;
        check("sticky_err_a", 32'(stall_err), 32'd1);
        tick();
        check("sticky_valid", 32'(out_valid), 32'd0);
        check("sticky_err_b", 32'(stall_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", 32'(stall_err), 32'd0);

        // Grant requester 3 so the pointer wraps to 0.
        req_valid = 4'b1000;
        req_fmsg  = 32'h3300_0000;
        tick();
        check("wrap_src", 32'(out_src), 32'd3);

        // Requester 0 (TYPE 00) against requester 3 (TYPE 11) with pointer at 0.
        req_valid = 4'b1001;
        req_fmsg  = 32'hC200_0001;
        #1;
`ifdef FMSG_ARB_URGENT_PRIO_EN
        check("prio_ready_a", 32'(req_ready), 32'b1000);
        tick();
        check("prio_src_a",   32'(out_src),   32'd3);
        check("prio_fmsg_a",  32'(out_fmsg),  32'hC2);
        check("prio_ready_b", 32'(req_ready), 32'b1000);
        tick();
        check("prio_src_b",   32'(out_src),   32'd3);
`else
        check("prio_ready_a", 32'(req_ready), 32'b0001);
        tick();
        check("prio_src_a",   32'(out_src),   32'd0);
        check("prio_fmsg_a",  32'(out_fmsg),  32'h01);
        check("prio_ready_b", 32'(req_ready), 32'b1000);
        tick();
        check("prio_src_b",   32'(out_src),   32'd3);
        check("prio_fmsg_b",  32'(out_fmsg),  32'hC2);
`endif

        // Mid-run reset: packet dropped at once, pointer back to 0.
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_valid_hold", 32'(out_valid), 32'd0);
`ifdef FMSG_ARB_URGENT_PRIO_EN
        check("post_rst_ready", 32'(req_ready), 32'b1000);
        tick();
        check("post_rst_src",   32'(out_src),   32'd3);
`else
        check("post_rst_ready", 32'(req_ready), 32'b0001);
        tick();
        check("post_rst_src",   32'(out_src),   32'd0);
        check("post_rst_fmsg",  32'(out_fmsg),  32'h01);
`endif

        // No requests: nothing granted, output drains.
        req_valid = 4'b0000;
        #1;
        check("idle_ready", 32'(req_ready), 32'd0);
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmsg_arbiter.md
FMSG_ARBITER -- requirements
Module: fmsg_arbiter

Interface
REQ-001 Parameter: STALL_LIMIT, default 255, output-stall cycles before stall_err sets (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  4  requester i offers an fmsg (i = 0..3).
REQ-005 req_fmsg  input  32  packed fmsg words; requester i on bits [8i+7:8i].
REQ-006 req_ready  output  4  one-hot grant/accept strobe; at most one bit high.
REQ-007 out_valid  output  1  out_fmsg holds a packet.
REQ-008 out_fmsg  output  8  arbitrated fmsg; TYPE [7:6], DEST [5:4], PAYLOAD [3:0].
REQ-009 out_src  output  2  index of the requester that supplied out_fmsg.
REQ-010 out_ready  input  1  downstream accepts out_fmsg when high with out_valid.
REQ-011 err_clr  input  1  clears stall_err.
REQ-012 stall_err  output  1  sticky downstream-stall flag.

Function
REQ-013 A transfer from requester i occurs in a cycle with req_valid[i] & req_ready[i] both high; the output transfer occurs with out_valid & out_ready both high.
REQ-014 Load condition: load = !out_valid | out_ready; req_ready SHALL be all-zero when load is low.
REQ-015 When load is high and any req_valid is set, req_ready SHALL be one-hot on the winner; when no req_valid is set, req_ready SHALL be 0.
REQ-016 Winner: first set req_valid bit scanning from rr_ptr upward, wrapping 3 -> 0.
REQ-017 rr_ptr is a 2-bit register; after a transfer from requester i it SHALL become (i+1) mod 4; otherwise it holds.
REQ-018 On a transfer from requester i, next cycle: out_valid = 1, out_fmsg = that word, out_src = i (latency 1 cycle).
REQ-019 When an output transfer occurs with no new transfer, out_valid SHALL fall to 0 next cycle; out_fmsg and out_src hold their last values.
REQ-020 Simultaneous output transfer and new transfer: out register reloads in the same edge; throughput 1 packet/cycle with out_ready held high.
REQ-021 While out_valid & !out_ready, out_fmsg and out_src SHALL remain stable.
REQ-022 Arbitration is re-evaluated every load cycle; no lock; a requester dropping req_valid before grant loses no state.
REQ-023 stall_cnt (8-bit): increments each cycle with out_valid & !out_ready, saturates at STALL_LIMIT, clears to 0 on any cycle without that condition.
REQ-024 stall_err SHALL set in the cycle after stall_cnt reaches STALL_LIMIT and remain set until err_clr; err_clr and a set condition in the same cycle: set wins.
REQ-025 State machine: IDLE (out_valid = 0) -> FULL on transfer; FULL -> FULL on output transfer with new transfer or while stalled; FULL -> IDLE on output transfer without new transfer.

Reset
REQ-026 While rst is high: out_valid = 0, out_fmsg = 8'h00, out_src = 0, rr_ptr = 0, stall_cnt = 0, stall_err = 0, state = IDLE; req_ready = 0.
REQ-027 Reset asserted mid-operation SHALL discard any held packet; no packet is replayed after release.
REQ-028 First arbitration after reset release SHALL favour requester 0.

Configuration
REQ-029 Macro FMSG_ARB_URGENT_PRIO_EN: when defined, requests whose fmsg TYPE = 2'b11 form an urgent set; if non-empty, the winner SHALL be chosen from it by the REQ-016 scan, and the REQ-017 rr_ptr update applies.
REQ-030 When FMSG_ARB_URGENT_PRIO_EN is undefined, TYPE is ignored and plain round-robin per REQ-016 applies.

Verification
REQ-031 req_valid = 4'b1111 all cycles, out_ready = 1 -> out_src sequence 0,1,2,3,0, one packet per cycle, first out_valid 1 cycle after first grant.
REQ-032 req_valid = 4'b0100 with fmsg 8'hA5, out_ready = 0 for 5 cycles -> out_fmsg = 8'hA5, out_src = 2 held stable, req_ready = 0 after the first grant.
REQ-033 STALL_LIMIT = 3, out_valid held with out_ready = 0 for 5 cycles -> stall_err = 1 from the 4th stalled cycle; err_clr pulse after out_ready = 1 -> stall_err = 0.
REQ-034 Macro defined: req0 = 8'h01, req3 = 8'hC2 valid together, rr_ptr = 0 -> requester 3 granted first, out_fmsg = 8'hC2; macro undefined -> requester 0 first.
REQ-035 rst pulsed while out_valid = 1 -> out_valid = 0 immediately, next grant goes to requester 0 with req_valid = 4'b1001.
